// File: rtl/usb_boot_pkg.sv
// Shared types and constants for the USB bootloader exit sequencer.
package usb_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DETACH = 3'd3,
        ST_BOOT   = 3'd4
    } boot_state_e;

    localparam logic [1:0] WB_IMG_BOOTLOADER = 2'd0;
    localparam logic [1:0] WB_IMG_USER       = 2'd1;

endpackage

// File: rtl/boot_phase_timer.sv
// Loadable down-counter; done is high for the single cycle in which an armed count sits at zero.
module boot_phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;
    logic             armed;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_value;
            armed <= 1'b1;
        end else if (armed) begin
            if (count == '0) begin
                armed <= 1'b0;
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

    // A load of N-1 makes done fire N cycles after the load edge.
    assign done = armed && (count == '0);

endmodule

// File: rtl/usb_boot_ctrl.sv
// Bootloader exit sequencer: host presence watch, drain, detach, then SB_WARMBOOT with a latched image.
module usb_boot_ctrl
    import usb_boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 48000000,
    parameter int unsigned DRAIN_CYCLES   = 48000,
    parameter int unsigned DETACH_CYCLES  = 480000,
    parameter logic [1:0]  DEFAULT_IMAGE  = WB_IMG_USER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof_valid,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    output logic       host_present,
    output logic       usb_detach,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic [2:0] state_o
);

    localparam int unsigned TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PHASE_MAX = (DRAIN_CYCLES > DETACH_CYCLES) ? DRAIN_CYCLES : DETACH_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);

    boot_state_e        state_q, state_d;
    logic [TIMER_W-1:0] presence_timer;
    logic [1:0]         wb_img_q, wb_img_d;
    logic               phase_load;
    logic [PHASE_W-1:0] phase_value;
    logic               phase_done;
    logic               in_watch;
    logic               timeout;

    assign in_watch = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    // sof_valid in the would-be timeout cycle suppresses the timeout.
    assign timeout  = (presence_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) && !sof_valid;

    boot_phase_timer #(
        .WIDTH (PHASE_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (phase_load),
        .load_value (phase_value),
        .done       (phase_done)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        state_d     = state_q;
        wb_img_d    = wb_img_q;
        phase_load  = 1'b0;
        phase_value = '0;
        unique case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (boot_req) begin
                    state_d     = ST_DRAIN;
                    wb_img_d    = boot_image;
                    phase_load  = 1'b1;
                    phase_value = PHASE_W'(DRAIN_CYCLES - 1);
                end else if (timeout) begin
                    state_d     = ST_DRAIN;
                    wb_img_d    = DEFAULT_IMAGE;
                    phase_load  = 1'b1;
                    phase_value = PHASE_W'(DRAIN_CYCLES - 1);
                end else if (sof_valid) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (phase_done) begin
                    state_d     = ST_DETACH;
                    phase_load  = 1'b1;
                    phase_value = PHASE_W'(DETACH_CYCLES - 1);
                end
            end
            ST_DETACH: begin
                if (phase_done) begin
                    state_d = ST_BOOT;
                end
            end
            ST_BOOT: state_d = ST_BOOT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            presence_timer <= '0;
            host_present   <= 1'b0;
            wb_img_q       <= WB_IMG_BOOTLOADER;
            usb_detach     <= 1'b0;
            wb_boot        <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_img_q <= wb_img_d;
            if (in_watch) begin
                if (sof_valid) begin
                    presence_timer <= '0;
                    host_present   <= 1'b1;
                end else if (presence_timer != TIMER_W'(TIMEOUT_CYCLES)) begin
                    presence_timer <= presence_timer + TIMER_W'(1);
                end
            end
            // Outputs are decoded from the next state so they stay pure registers.
            usb_detach <= (state_d == ST_DETACH) || (state_d == ST_BOOT);
            wb_boot    <= (state_d == ST_BOOT);
        end
    end

    assign wb_s1   = wb_img_q[1];
    assign wb_s0   = wb_img_q[0];
    assign state_o = state_q;

endmodule

// File: tb/tb_usb_boot_ctrl.sv
// Directed bench for usb_boot_ctrl with short timeouts; vector table plus multi-cycle sequences.
module tb_usb_boot_ctrl;

    localparam int unsigned TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof_valid = 1'b0;
    logic       boot_req = 1'b0;
    logic [1:0] boot_image = 2'd0;
    logic       host_present, usb_detach, wb_s1, wb_s0, wb_boot;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usb_boot_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .DRAIN_CYCLES   (4),
        .DETACH_CYCLES  (8),
        .DEFAULT_IMAGE  (2'd1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sof_valid    (sof_valid),
        .boot_req     (boot_req),
        .boot_image   (boot_image),
        .host_present (host_present),
        .usb_detach   (usb_detach),
        .wb_s1        (wb_s1),
        .wb_s0        (wb_s0),
        .wb_boot      (wb_boot),
        .state_o      (state_o)
    );

    typedef struct {
        bit         rst;
        bit         sof;
        bit         req;
        logic [1:0] img;
        bit         hp;
        bit         det;
        logic [1:0] wb;
        bit         boot;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(bit rst, bit sof, bit req, logic [1:0] img,
                                bit hp, bit det, logic [1:0] wb, bit boot, logic [2:0] st);
        vec_t v;
        v.rst = rst; v.sof = sof; v.req = req; v.img = img;
        v.hp = hp; v.det = det; v.wb = wb; v.boot = boot; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit hp, input bit det,
                              input logic [1:0] wb, input bit boot, input logic [2:0] st);
        check({tag, ".host_present"}, {7'd0, host_present}, {7'd0, hp});
        check({tag, ".usb_detach"},   {7'd0, usb_detach},   {7'd0, det});
        check({tag, ".wb_img"},       {6'd0, wb_s1, wb_s0}, {6'd0, wb});
        check({tag, ".wb_boot"},      {7'd0, wb_boot},      {7'd0, boot});
        check({tag, ".state"},        {5'd0, state_o},      {5'd0, st});
    endtask

    // Drive inputs for one cycle, then sample 1 ns after the edge.
    task automatic cyc(input bit r, input bit s, input bit b, input logic [1:0] img);
        reset      = r;
        sof_valid  = s;
        boot_req   = b;
        boot_image = img;
        @(posedge clk);
        #1;
        sof_valid = 1'b0;
        boot_req  = 1'b0;
    endtask

    initial begin
        // Reset from power-up, then let the presence timer expire with no SOF.
        cyc(1, 0, 0, 2'd0);
        check_outs("por", 0, 0, 2'd0, 0, 3'd0);
        cyc(1, 0, 0, 2'd0);
        cyc(1, 0, 0, 2'd0);
        for (int n = 1; n <= 112; n++) begin
            cyc(0, 0, 0, 2'd0);
            if (n == 99)  check_outs("to_e99",  0, 0, 2'd0, 0, 3'd0);
            if (n == 100) check_outs("to_e100", 0, 0, 2'd1, 0, 3'd2);
            if (n == 103) check_outs("to_e103", 0, 0, 2'd1, 0, 3'd2);
            if (n == 104) check_outs("to_e104", 0, 1, 2'd1, 0, 3'd3);
            if (n == 111) check_outs("to_e111", 0, 1, 2'd1, 0, 3'd3);
            if (n == 112) check_outs("to_e112", 0, 1, 2'd1, 1, 3'd4);
        end

        // Vector table: reset out of BOOT, then boot_req with image 2 and ignored late requests.
        vecs[0]  = mk(1, 1, 1, 2'd3, 0, 0, 2'd0, 0, 3'd0);
        vecs[1]  = mk(1, 1, 1, 2'd3, 0, 0, 2'd0, 0, 3'd0);
        vecs[2]  = mk(1, 1, 1, 2'd3, 0, 0, 2'd0, 0, 3'd0);
        vecs[3]  = mk(0, 1, 0, 2'd0, 1, 0, 2'd0, 0, 3'd1);
        vecs[4]  = mk(0, 0, 0, 2'd0, 1, 0, 2'd0, 0, 3'd1);
        vecs[5]  = mk(0, 0, 1, 2'd2, 1, 0, 2'd2, 0, 3'd2);
        vecs[6]  = mk(0, 0, 1, 2'd3, 1, 0, 2'd2, 0, 3'd2);
        vecs[7]  = mk(0, 1, 0, 2'd0, 1, 0, 2'd2, 0, 3'd2);
        vecs[8]  = mk(0, 0, 0, 2'd0, 1, 0, 2'd2, 0, 3'd2);
        vecs[9]  = mk(0, 0, 0, 2'd0, 1, 1, 2'd2, 0, 3'd3);
        vecs[10] = mk(0, 1, 1, 2'd1, 1, 1, 2'd2, 0, 3'd3);
        for (int i = 11; i <= 16; i++)
            vecs[i] = mk(0, 0, 0, 2'd0, 1, 1, 2'd2, 0, 3'd3);
        vecs[17] = mk(0, 0, 0, 2'd0, 1, 1, 2'd2, 1, 3'd4);
        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].rst, vecs[i].sof, vecs[i].req, vecs[i].img);
            check_outs($sformatf("vec%0d", i), vecs[i].hp, vecs[i].det, vecs[i].wb,
                       vecs[i].boot, vecs[i].st);
        end

        // SOF every 99 cycles keeps the host present; then a 100-cycle gap times out.
        cyc(1, 0, 0, 2'd0);
        for (int e = 1; e <= 2000; e++) begin
            cyc(0, ((e - 1) % 99) == 0, 0, 2'd0);
            check($sformatf("sof99_state_e%0d", e), {5'd0, state_o}, 8'd1);
            check($sformatf("sof99_boot_e%0d", e), {7'd0, wb_boot}, 8'd0);
        end
        check("sof99_host_present", {7'd0, host_present}, 8'd1);
        // Last SOF at edge 1981; 19 SOF-free edges so far, timeout on the 100th.
        for (int e = 1; e <= 80; e++) cyc(0, 0, 0, 2'd0);
        check_outs("gap99", 1, 0, 2'd0, 0, 3'd1);
        cyc(0, 0, 0, 2'd0);
        check_outs("gap100", 1, 0, 2'd1, 0, 3'd2);

        // SOF in the would-be timeout cycle, then boot_req in the next timeout cycle.
        cyc(1, 0, 0, 2'd0);
        cyc(0, 1, 0, 2'd0);
        for (int e = 1; e <= 99; e++) cyc(0, 0, 0, 2'd0);
        check_outs("pre_to", 1, 0, 2'd0, 0, 3'd1);
        cyc(0, 1, 0, 2'd0);
        check_outs("sof_wins", 1, 0, 2'd0, 0, 3'd1);
        for (int e = 1; e <= 99; e++) cyc(0, 0, 0, 2'd0);
        check_outs("restart", 1, 0, 2'd0, 0, 3'd1);
        cyc(0, 0, 1, 2'd0);
        check_outs("req_wins", 1, 0, 2'd0, 0, 3'd2);

        // Reset in the middle of DETACH, then normal operation on the next SOF.
        cyc(1, 0, 0, 2'd0);
        cyc(0, 1, 0, 2'd0);
        cyc(0, 0, 1, 2'd3);
        for (int e = 1; e <= 5; e++) cyc(0, 0, 0, 2'd0);
        check_outs("mid_detach", 1, 1, 2'd3, 0, 3'd3);
        cyc(1, 0, 0, 2'd0);
        check_outs("rst_detach", 0, 0, 2'd0, 0, 3'd0);
        cyc(0, 0, 0, 2'd0);
        check_outs("post_rst", 0, 0, 2'd0, 0, 3'd0);
        cyc(0, 1, 0, 2'd0);
        check_outs("resume", 1, 0, 2'd0, 0, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
